// File: rtl/gather_pkg.sv
// rtl/gather_pkg.sv - shared defaults and types for the gather-count bank
package gather_pkg;

    localparam int GATHER_NUM_WARP = 8;
    localparam int GATHER_CNT_W    = 4;
    localparam int GATHER_WID_W    = $clog2(GATHER_NUM_WARP);

    localparam logic [GATHER_CNT_W-1:0] GATHER_CNT_MAX = '1;

    typedef logic [GATHER_CNT_W-1:0] gather_cnt_t;

endpackage

// File: rtl/gather_cnt_upd.sv
// rtl/gather_cnt_upd.sv - next-value and flag function for one gather counter
//
// Ports:
//   i_cur      current counter value
//   i_add      amount to add (0 when no set targets this entry)
//   i_sub      amount to subtract (0 when no dec targets this entry)
//   i_collide  set and dec hit this entry in the same cycle; the dec is dropped
//   o_next     next counter value
//   o_ovf      the add saturated
//   o_udf      the dec exceeded the counter, or a collision occurred
//   o_hit_zero a dec took the counter from nonzero to zero
module gather_cnt_upd
    import gather_pkg::*;
#(
    parameter int CNT_W = GATHER_CNT_W
) (
    input  logic [CNT_W-1:0] i_cur,
    input  logic [CNT_W-1:0] i_add,
    input  logic [CNT_W-1:0] i_sub,
    input  logic             i_collide,
    output logic [CNT_W-1:0] o_next,
    output logic             o_ovf,
    output logic             o_udf,
    output logic             o_hit_zero
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // One extra bit so the carry out is the overflow indication.
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_added;

    assign w_sum   = {1'b0, i_cur} + {1'b0, i_add};
    assign w_added = w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];

    // A set and a dec only reach the same entry on a collision, so the
    // subtract path never has to combine with a nonzero add.
    always_comb begin
        o_next     = w_added;
        o_ovf      = w_sum[CNT_W];
        o_udf      = 1'b0;
        o_hit_zero = 1'b0;
        if (i_collide) begin
            o_udf = 1'b1;
        end else if (i_sub != '0) begin
            if (i_sub <= i_cur) begin
                o_next     = i_cur - i_sub;
                o_hit_zero = (i_sub == i_cur);
            end else begin
                o_next     = '0;
                o_udf      = 1'b1;
                o_hit_zero = (i_cur != '0);
            end
        end
    end

endmodule

// File: rtl/wf_gather_cnt_bank.sv
// rtl/wf_gather_cnt_bank.sv - per-warp outstanding gather-response counter bank
//
// Ports:
//   i_clock, i_reset_n                 clock, async active-low reset
//   i_set_en/i_set_warp/i_set_val      add responses expected to a warp
//   i_dec_en/i_dec_warp/i_dec_amt      subtract responses returned from a warp
//   i_rd_en/i_rd_warp, o_rd_data       registered read, write-first
//   o_busy                             per-warp counter-nonzero bitmap
//   o_done_valid/o_done_warp           pulse when a dec brings a counter to zero
//   o_err_ovf/o_err_udf                sticky overflow / underflow-collision flags
module wf_gather_cnt_bank
    import gather_pkg::*;
#(
    parameter  int NUM_WARP = GATHER_NUM_WARP,
    parameter  int CNT_W    = GATHER_CNT_W,
    localparam int WID_W    = $clog2(NUM_WARP)
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic                i_set_en,
    input  logic [WID_W-1:0]    i_set_warp,
    input  logic [CNT_W-1:0]    i_set_val,
    input  logic                i_dec_en,
    input  logic [WID_W-1:0]    i_dec_warp,
    input  logic [CNT_W-1:0]    i_dec_amt,
    input  logic                i_rd_en,
    input  logic [WID_W-1:0]    i_rd_warp,
    output logic [CNT_W-1:0]    o_rd_data,
    output logic [NUM_WARP-1:0] o_busy,
    output logic                o_done_valid,
    output logic [WID_W-1:0]    o_done_warp,
    output logic                o_err_ovf,
    output logic                o_err_udf
);

    logic [CNT_W-1:0]    r_cnt [NUM_WARP];
    logic [CNT_W-1:0]    w_next [NUM_WARP];
    logic [NUM_WARP-1:0] w_ovf;
    logic [NUM_WARP-1:0] w_udf;
    logic [NUM_WARP-1:0] w_hit;
    logic [NUM_WARP-1:0] w_busy_nxt;

    logic [CNT_W-1:0]    r_rd_data;
    logic [NUM_WARP-1:0] r_busy;
    logic                r_done_valid;
    logic [WID_W-1:0]    r_done_warp;
    logic                r_err_ovf;
    logic                r_err_udf;

    for (genvar g = 0; g < NUM_WARP; g++) begin : g_ent
        logic w_set_hit;
        logic w_dec_hit;

        assign w_set_hit = i_set_en && (i_set_warp == WID_W'(g));
        assign w_dec_hit = i_dec_en && (i_dec_warp == WID_W'(g));

        gather_cnt_upd #(
            .CNT_W (CNT_W)
        ) u_upd (
            .i_cur      (r_cnt[g]),
            .i_add      (w_set_hit ? i_set_val : '0),
            .i_sub      (w_dec_hit ? i_dec_amt : '0),
            .i_collide  (w_set_hit && w_dec_hit),
            .o_next     (w_next[g]),
            .o_ovf      (w_ovf[g]),
            .o_udf      (w_udf[g]),
            .o_hit_zero (w_hit[g])
        );

        assign w_busy_nxt[g] = (w_next[g] != '0);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_WARP; i++) begin
                r_cnt[i] <= '0;
            end
            r_busy       <= '0;
            r_rd_data    <= '0;
            r_done_valid <= 1'b0;
            r_done_warp  <= '0;
            r_err_ovf    <= 1'b0;
            r_err_udf    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WARP; i++) begin
                r_cnt[i] <= w_next[i];
            end
            r_busy <= w_busy_nxt;
            // Read returns the post-update value so a same-cycle set/dec is seen.
            if (i_rd_en) begin
                r_rd_data <= w_next[i_rd_warp];
            end
            // Only the dec target can hit zero, so the dec index names the event.
            r_done_valid <= |w_hit;
            if (|w_hit) begin
                r_done_warp <= i_dec_warp;
            end
            r_err_ovf <= r_err_ovf | (|w_ovf);
            r_err_udf <= r_err_udf | (|w_udf);
        end
    end

    assign o_rd_data    = r_rd_data;
    assign o_busy       = r_busy;
    assign o_done_valid = r_done_valid;
    assign o_done_warp  = r_done_warp;
    assign o_err_ovf    = r_err_ovf;
    assign o_err_udf    = r_err_udf;

endmodule

// File: tb/tb_wf_gather_cnt_bank.sv
// tb/tb_wf_gather_cnt_bank.sv - directed self-checking bench for wf_gather_cnt_bank
module tb_wf_gather_cnt_bank;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default build: 8 warps, 4-bit counters
    logic       a_set_en, a_dec_en, a_rd_en;
    logic [2:0] a_set_warp, a_dec_warp, a_rd_warp;
    logic [3:0] a_set_val, a_dec_amt;
    logic [3:0] a_rd_data;
    logic [7:0] a_busy;
    logic       a_done_valid, a_err_ovf, a_err_udf;
    logic [2:0] a_done_warp;

    // Wide build: 16 warps, 6-bit counters
    logic        b_set_en, b_dec_en, b_rd_en;
    logic [3:0]  b_set_warp, b_dec_warp, b_rd_warp;
    logic [5:0]  b_set_val, b_dec_amt;
    logic [5:0]  b_rd_data;
    logic [15:0] b_busy;
    logic        b_done_valid, b_err_ovf, b_err_udf;
    logic [3:0]  b_done_warp;

    wf_gather_cnt_bank u_dut_a (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_set_en     (a_set_en),
        .i_set_warp   (a_set_warp),
        .i_set_val    (a_set_val),
        .i_dec_en     (a_dec_en),
        .i_dec_warp   (a_dec_warp),
        .i_dec_amt    (a_dec_amt),
        .i_rd_en      (a_rd_en),
        .i_rd_warp    (a_rd_warp),
        .o_rd_data    (a_rd_data),
        .o_busy       (a_busy),
        .o_done_valid (a_done_valid),
        .o_done_warp  (a_done_warp),
        .o_err_ovf    (a_err_ovf),
        .o_err_udf    (a_err_udf)
    );

    wf_gather_cnt_bank #(
        .NUM_WARP (16),
        .CNT_W    (6)
    ) u_dut_b (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_set_en     (b_set_en),
        .i_set_warp   (b_set_warp),
        .i_set_val    (b_set_val),
        .i_dec_en     (b_dec_en),
        .i_dec_warp   (b_dec_warp),
        .i_dec_amt    (b_dec_amt),
        .i_rd_en      (b_rd_en),
        .i_rd_warp    (b_rd_warp),
        .o_rd_data    (b_rd_data),
        .o_busy       (b_busy),
        .o_done_valid (b_done_valid),
        .o_done_warp  (b_done_warp),
        .o_err_ovf    (b_err_ovf),
        .o_err_udf    (b_err_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_set_en = 1'b0; a_dec_en = 1'b0; a_rd_en = 1'b0;
    endtask

    task automatic a_set(input logic [2:0] w, input logic [3:0] v);
        a_set_en = 1'b1; a_set_warp = w; a_set_val = v;
    endtask

    task automatic a_dec(input logic [2:0] w, input logic [3:0] v);
        a_dec_en = 1'b1; a_dec_warp = w; a_dec_amt = v;
    endtask

    task automatic a_rd(input logic [2:0] w);
        a_rd_en = 1'b1; a_rd_warp = w;
    endtask

    initial begin
        rst_n = 1'b0;
        a_set_en = 0; a_set_warp = 0; a_set_val = 0;
        a_dec_en = 0; a_dec_warp = 0; a_dec_amt = 0;
        a_rd_en  = 0; a_rd_warp  = 0;
        b_set_en = 0; b_set_warp = 0; b_set_val = 0;
        b_dec_en = 0; b_dec_warp = 0; b_dec_amt = 0;
        b_rd_en  = 0; b_rd_warp  = 0;
        tick();
        tick();
        chk("rst_busy",  32'(a_busy), 32'h00);
        chk("rst_rd",    32'(a_rd_data), 32'h0);
        chk("rst_done",  32'(a_done_valid), 32'h0);
        chk("rst_dwarp", 32'(a_done_warp), 32'h0);
        chk("rst_ovf",   32'(a_err_ovf), 32'h0);
        chk("rst_udf",   32'(a_err_udf), 32'h0);
        rst_n = 1'b1;

        a_rd(3'd3); tick(); a_idle();
        chk("rd3_after_rst", 32'(a_rd_data), 32'h0);

        // Arm warp2 with 5, drain it in two decs
        a_set(3'd2, 4'd5); tick(); a_idle();
        chk("s2_busy_set", 32'(a_busy), 32'h04);
        a_dec(3'd2, 4'd2); tick(); a_idle();
        chk("s2_busy_dec1", 32'(a_busy), 32'h04);
        chk("s2_nodone",    32'(a_done_valid), 32'h0);
        a_dec(3'd2, 4'd3); tick(); a_idle();
        chk("s2_busy_dec2", 32'(a_busy), 32'h00);
        chk("s2_done",      32'(a_done_valid), 32'h1);
        chk("s2_done_warp", 32'(a_done_warp), 32'h2);
        tick();
        chk("s2_done_pulse", 32'(a_done_valid), 32'h0);
        chk("s2_udf_clean",  32'(a_err_udf), 32'h0);

        // Saturation on warp1: 12 + 7 clamps at 15
        a_set(3'd1, 4'd12); tick(); a_idle();
        chk("s3_no_ovf_yet", 32'(a_err_ovf), 32'h0);
        a_set(3'd1, 4'd7); tick(); a_idle();
        chk("s3_ovf", 32'(a_err_ovf), 32'h1);
        a_rd(3'd1); tick(); a_idle();
        chk("s3_sat_val", 32'(a_rd_data), 32'hF);
        chk("s3_ovf_sticky", 32'(a_err_ovf), 32'h1);
        chk("s3_busy", 32'(a_busy), 32'h02);
        chk("s3_udf", 32'(a_err_udf), 32'h0);

        // Collision on warp6, then independent set/dec on warps 0 and 5
        a_set(3'd5, 4'd1); tick(); a_idle();
        a_set(3'd6, 4'd4); a_dec(3'd6, 4'd1); tick(); a_idle();
        chk("s5_coll_udf",  32'(a_err_udf), 32'h1);
        chk("s5_coll_busy", 32'(a_busy), 32'h62);
        chk("s5_coll_nodone", 32'(a_done_valid), 32'h0);
        a_rd(3'd6); tick(); a_idle();
        chk("s5_coll_val", 32'(a_rd_data), 32'h4);
        a_set(3'd0, 4'd2); a_dec(3'd5, 4'd1); tick(); a_idle();
        chk("s5_done",      32'(a_done_valid), 32'h1);
        chk("s5_done_warp", 32'(a_done_warp), 32'h5);
        chk("s5_busy",      32'(a_busy), 32'h43);
        a_rd(3'd0); tick(); a_idle();
        chk("s5_w0_val", 32'(a_rd_data), 32'h2);

        // Asynchronous reset mid-cycle with a set on the bus
        a_set(3'd3, 4'd2);
        a_dec(3'd0, 4'd2);
        tick();
        chk("pre_arst_done", 32'(a_done_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(a_busy), 32'h00);
        chk("arst_rd",   32'(a_rd_data), 32'h0);
        chk("arst_done", 32'(a_done_valid), 32'h0);
        chk("arst_ovf",  32'(a_err_ovf), 32'h0);
        chk("arst_udf",  32'(a_err_udf), 32'h0);
        tick();
        a_idle();
        rst_n = 1'b1;
        chk("arst_held_busy", 32'(a_busy), 32'h00);

        // Underflow clamp on warp4: 3 - 5 -> 0 with done
        a_set(3'd4, 4'd3); tick(); a_idle();
        a_dec(3'd4, 4'd5); tick(); a_idle();
        chk("s4_udf",       32'(a_err_udf), 32'h1);
        chk("s4_done",      32'(a_done_valid), 32'h1);
        chk("s4_done_warp", 32'(a_done_warp), 32'h4);
        chk("s4_busy",      32'(a_busy), 32'h00);
        a_dec(3'd4, 4'd1); a_rd(3'd4); tick(); a_idle();
        chk("s4_no_done", 32'(a_done_valid), 32'h0);
        chk("s4_val",     32'(a_rd_data), 32'h0);
        chk("s4_ovf",     32'(a_err_ovf), 32'h0);

        // Write-first read bypass on warp7, then hold with rd_en low
        a_set(3'd7, 4'd9); a_rd(3'd7); tick(); a_idle();
        chk("s6_bypass", 32'(a_rd_data), 32'h9);
        a_dec(3'd7, 4'd4); tick(); a_idle();
        chk("s6_hold", 32'(a_rd_data), 32'h9);
        a_rd(3'd7); tick(); a_idle();
        chk("s6_after_dec", 32'(a_rd_data), 32'h5);

        // Wide build: drain warp10 and saturate warp1 at 63
        b_set_en = 1'b1; b_set_warp = 4'd10; b_set_val = 6'd50; tick(); b_set_en = 1'b0;
        chk("b_busy_set", 32'(b_busy), 32'h0400);
        b_dec_en = 1'b1; b_dec_warp = 4'd10; b_dec_amt = 6'd20; tick();
        chk("b_nodone", 32'(b_done_valid), 32'h0);
        b_dec_amt = 6'd30; tick(); b_dec_en = 1'b0;
        chk("b_done",      32'(b_done_valid), 32'h1);
        chk("b_done_warp", 32'(b_done_warp), 32'hA);
        chk("b_busy_clr",  32'(b_busy), 32'h0000);
        chk("b_udf",       32'(b_err_udf), 32'h0);
        b_set_en = 1'b1; b_set_warp = 4'd1; b_set_val = 6'd40; tick();
        chk("b_no_ovf", 32'(b_err_ovf), 32'h0);
        b_set_val = 6'd30; b_rd_en = 1'b1; b_rd_warp = 4'd1; tick();
        b_set_en = 1'b0; b_rd_en = 1'b0;
        chk("b_sat_val", 32'(b_rd_data), 32'h3F);
        chk("b_ovf",     32'(b_err_ovf), 32'h1);
        chk("b_busy",    32'(b_busy), 32'h0002);
        chk("a_isolated_ovf", 32'(a_err_ovf), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
